// File: rtl/sat_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : sat_accum_seq (with helper sat_addsub16)
// Brief    : Sequential 16-bit signed saturating accumulator. Folds a stream
//            of operands into a running total one per cycle, then presents
//            the total with Z/N/V flags over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// sat_addsub16 : combinational 16-bit two's-complement add/sub with clamping.
// Subtraction goes through ~b + 1, so 0 - 8000 overflows and clamps to 7FFF.
// ----------------------------------------------------------------------------
module sat_addsub16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] y,
    output logic        ovf
);

    logic [15:0] w_b_eff;
    logic [15:0] w_raw;

    assign w_b_eff = sub ? ~b : b;
    assign w_raw   = a + w_b_eff + {15'd0, sub};

    // Signed overflow: both addends share a sign and the raw sum flips it.
    assign ovf = (a[15] == w_b_eff[15]) && (w_raw[15] != a[15]);

    // Positive operand overflow clamps high, negative clamps low.
    assign y = ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : w_raw;

endmodule

// ----------------------------------------------------------------------------
// sat_accum_seq : IDLE -> ACC (consume operands) -> DONE (hold result).
// ----------------------------------------------------------------------------
module sat_accum_seq #(
    parameter int MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] init_val,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_sub,
    input  logic        in_last,
    output logic        in_ready,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic        term_err
);

    localparam int                 c_cnt_w = $clog2(MAX_TERMS + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_TERMS);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_acc;
    logic [c_cnt_w-1:0] r_count;
    logic               r_v;
    logic               r_term;
    logic [15:0]        r_result;
    logic               r_z;
    logic               r_n;

    logic [15:0]        w_sum;
    logic               w_ovf;
    logic               w_xfer;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               w_hit_max;
    logic               w_finish;

    sat_addsub16 u_addsub (
        .a   (r_acc),
        .b   (in_data),
        .sub (in_sub),
        .y   (w_sum),
        .ovf (w_ovf)
    );

    assign w_xfer      = in_valid && (r_state == ACC);
    assign w_count_nxt = r_count + c_one;
    assign w_hit_max   = (w_count_nxt == c_max);
    // An explicit last operand wins over the term limit on the same transfer.
    assign w_finish    = w_xfer && (in_last || w_hit_max);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_nxt = ACC;
            ACC:     if (w_finish)  w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Accumulator, term counter and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 16'h0000;
            r_count  <= '0;
            r_v      <= 1'b0;
            r_term   <= 1'b0;
            r_result <= 16'h0000;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_acc    <= init_val;
            r_count  <= '0;
            r_v      <= 1'b0;
            r_term   <= 1'b0;
            r_result <= 16'h0000;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
        end else if (w_xfer) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            r_v     <= r_v | w_ovf;
            if (w_finish) begin
                r_result <= w_sum;
                r_z      <= (w_sum == 16'h0000);
                r_n      <= w_sum[15];
                r_term   <= !in_last;
            end
        end
    end

    assign in_ready  = (r_state == ACC);
    assign busy      = (r_state == ACC) || (r_state == DONE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_v    = r_v;
    assign term_err  = r_term;

endmodule
`default_nettype wire
